// File: rtl/pueo_trig_pkg.sv
// rtl/pueo_trig_pkg.sv - shared types and constants for the L2 trigger collector
package pueo_trig_pkg;

    localparam int TS_WIDTH   = 48;
    localparam int CNT_WIDTH  = 16;
    localparam int META_WORDS = 4;
    localparam int EVT_BEATS  = 5;

    // One queued trigger record; meta[0] carries TIO0 metadata.
    typedef struct packed {
        logic [TS_WIDTH-1:0]                 ts;
        logic [CNT_WIDTH-1:0]                count;
        logic [META_WORDS-1:0][63:0]         meta;
    } evt_rec_t;

    typedef enum logic {
        ST_IDLE,
        ST_SEND
    } rd_state_e;

endpackage

// File: rtl/pueo_evt_fifo.sv
// rtl/pueo_evt_fifo.sv - event record FIFO with registered first-word-fall-through head
//
// Ports:
//   clk_i, rst_i      clock, asynchronous active-high reset
//   push_i, din_i     write a record (accepted when not full, or when full and popping)
//   pop_i             drop the current head record
//   dout_o            registered head record, valid while empty_o is low
//   empty_o, full_o   occupancy flags
//   count_o           occupancy, 0..2^DEPTH_LOG2
module pueo_evt_fifo
    import pueo_trig_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  push_i,
    input  evt_rec_t              din_i,
    input  logic                  pop_i,
    output evt_rec_t              dout_o,
    output logic                  empty_o,
    output logic                  full_o,
    output logic [DEPTH_LOG2:0]   count_o
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

    evt_rec_t                mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0]   wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0]   rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]     count_q, count_d;
    evt_rec_t                dout_q, dout_d;
    logic                    do_push, do_pop;

    always_comb begin
        do_pop   = pop_i && (count_q != '0);
        do_push  = push_i && ((count_q != FULL_CNT) || do_pop);
        wr_ptr_d = wr_ptr_q + {{(DEPTH_LOG2-1){1'b0}}, do_push};
        rd_ptr_d = rd_ptr_q + {{(DEPTH_LOG2-1){1'b0}}, do_pop};
        count_d  = count_q + {{DEPTH_LOG2{1'b0}}, do_push} - {{DEPTH_LOG2{1'b0}}, do_pop};
        // Head register tracks the next head. When the record being written
        // lands exactly at the next head slot, the memory still holds stale
        // data this cycle, so forward the incoming record instead.
        if (do_push && (wr_ptr_q == rd_ptr_d)) begin
            dout_d = din_i;
        end else begin
            dout_d = mem_q[rd_ptr_d];
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            dout_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            dout_q   <= dout_d;
        end
    end

    assign dout_o  = dout_q;
    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == FULL_CNT);
    assign count_o = count_q;

endmodule

// File: rtl/pueo_trig_collector.sv
// rtl/pueo_trig_collector.sv - timestamps, numbers and queues L2 triggers, streams them as 5-beat records
//
// Ports:
//   clk_i, rst_i                 clock, asynchronous active-high reset
//   ce_i                         holdoff count enable
//   run_en_i                     trigger acceptance enable
//   trig_i, tio0..3_meta_i       trigger pulse and its metadata (same cycle)
//   holdoff_len_i                holdoff length in ce_i ticks
//   holdoff_o, dead_o            feedback to the L2 trigger
//   evt_tdata/tvalid/tready/tlast  record stream: {ts,count}, meta0..meta3
//   drop_count_o                 saturating count of triggers lost to a full queue
module pueo_trig_collector
    import pueo_trig_pkg::*;
#(
    parameter int FIFO_DEPTH_LOG2 = 4,
    parameter int HOLDOFF_WIDTH   = 16
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      ce_i,
    input  logic                      run_en_i,
    input  logic                      trig_i,
    input  logic [63:0]               tio0_meta_i,
    input  logic [63:0]               tio1_meta_i,
    input  logic [63:0]               tio2_meta_i,
    input  logic [63:0]               tio3_meta_i,
    input  logic [HOLDOFF_WIDTH-1:0]  holdoff_len_i,
    output logic                      holdoff_o,
    output logic                      dead_o,
    output logic [63:0]               evt_tdata,
    output logic                      evt_tvalid,
    input  logic                      evt_tready,
    output logic                      evt_tlast,
    output logic [15:0]               drop_count_o
);

    localparam logic [2:0] LAST_BEAT = 3'(EVT_BEATS - 1);
    localparam logic [FIFO_DEPTH_LOG2:0] ONE_REC = {{FIFO_DEPTH_LOG2{1'b0}}, 1'b1};

    logic [TS_WIDTH-1:0]       ts_q, ts_d;
    logic [CNT_WIDTH-1:0]      trig_cnt_q, trig_cnt_d;
    logic [15:0]               drop_cnt_q, drop_cnt_d;
    logic [HOLDOFF_WIDTH-1:0]  hold_cnt_q, hold_cnt_d;
    logic                      holdoff_q, holdoff_d;
    logic                      dead_q, dead_d;
    rd_state_e                 state_q, state_d;
    logic [2:0]                beat_q, beat_d;

    logic                      accept, push, pop;
    logic                      fifo_empty, fifo_full;
    logic [FIFO_DEPTH_LOG2:0]  fifo_count;
    evt_rec_t                  rec_in, rec_out;

    pueo_evt_fifo #(
        .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push),
        .din_i   (rec_in),
        .pop_i   (pop),
        .dout_o  (rec_out),
        .empty_o (fifo_empty),
        .full_o  (fifo_full),
        .count_o (fifo_count)
    );

    // Capture, holdoff and dead generation.
    always_comb begin
        rec_in.ts      = ts_q;
        rec_in.count   = trig_cnt_q;
        rec_in.meta[0] = tio0_meta_i;
        rec_in.meta[1] = tio1_meta_i;
        rec_in.meta[2] = tio2_meta_i;
        rec_in.meta[3] = tio3_meta_i;

        accept = trig_i && run_en_i;
        pop    = (state_q == ST_SEND) && (beat_q == LAST_BEAT) && evt_tready;
        // A full queue still takes the trigger if a record leaves this cycle.
        push   = accept && (!fifo_full || pop);

        ts_d       = ts_q + TS_WIDTH'(1);
        trig_cnt_d = trig_cnt_q + CNT_WIDTH'(push);
        drop_cnt_d = drop_cnt_q;
        if (accept && !push && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end

        hold_cnt_d = hold_cnt_q;
        if (push) begin
            hold_cnt_d = holdoff_len_i;
        end else if (ce_i && (hold_cnt_q != '0)) begin
            hold_cnt_d = hold_cnt_q - HOLDOFF_WIDTH'(1);
        end
        holdoff_d = (hold_cnt_d != '0);
        dead_d    = fifo_full || !run_en_i;
    end

    // Readout FSM; tdata only changes on a handshake, so it holds under stall.
    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        evt_tvalid = 1'b0;
        evt_tlast  = 1'b0;
        evt_tdata  = '0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    state_d = ST_SEND;
                    beat_d  = '0;
                end
            end
            ST_SEND: begin
                evt_tvalid = 1'b1;
                evt_tlast  = (beat_q == LAST_BEAT);
                case (beat_q)
                    3'd0:    evt_tdata = {rec_out.ts, rec_out.count};
                    3'd1:    evt_tdata = rec_out.meta[0];
                    3'd2:    evt_tdata = rec_out.meta[1];
                    3'd3:    evt_tdata = rec_out.meta[2];
                    3'd4:    evt_tdata = rec_out.meta[3];
                    default: evt_tdata = '0;
                endcase
                if (evt_tready) begin
                    if (beat_q == LAST_BEAT) begin
                        beat_d  = '0;
                        // Stay in SEND when another record remains after this pop.
                        state_d = ((fifo_count != ONE_REC) || push) ? ST_SEND : ST_IDLE;
                    end else begin
                        beat_d = beat_q + 3'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ts_q       <= '0;
            trig_cnt_q <= '0;
            drop_cnt_q <= '0;
            hold_cnt_q <= '0;
            holdoff_q  <= 1'b0;
            dead_q     <= 1'b1;
            state_q    <= ST_IDLE;
            beat_q     <= '0;
        end else begin
            ts_q       <= ts_d;
            trig_cnt_q <= trig_cnt_d;
            drop_cnt_q <= drop_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            holdoff_q  <= holdoff_d;
            dead_q     <= dead_d;
            state_q    <= state_d;
            beat_q     <= beat_d;
        end
    end

    assign holdoff_o    = holdoff_q;
    assign dead_o       = dead_q;
    assign drop_count_o = drop_cnt_q;

endmodule

// File: tb/tb_pueo_trig_collector.sv
// tb/tb_pueo_trig_collector.sv - self-checking bench for pueo_trig_collector
module tb_pueo_trig_collector;
    import pueo_trig_pkg::*;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        ce_i = 1'b0;
    logic        run_en_i = 1'b0;
    logic        trig_i = 1'b0;
    logic [63:0] tio0 = '0, tio1 = '0, tio2 = '0, tio3 = '0;
    logic [15:0] holdoff_len = '0;
    logic        holdoff_o, dead_o;
    logic [63:0] evt_tdata;
    logic        evt_tvalid, evt_tlast;
    logic        evt_tready = 1'b0;
    logic [15:0] drop_count_o;

    pueo_trig_collector #(
        .FIFO_DEPTH_LOG2 (4),
        .HOLDOFF_WIDTH   (16)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .ce_i          (ce_i),
        .run_en_i      (run_en_i),
        .trig_i        (trig_i),
        .tio0_meta_i   (tio0),
        .tio1_meta_i   (tio1),
        .tio2_meta_i   (tio2),
        .tio3_meta_i   (tio3),
        .holdoff_len_i (holdoff_len),
        .holdoff_o     (holdoff_o),
        .dead_o        (dead_o),
        .evt_tdata     (evt_tdata),
        .evt_tvalid    (evt_tvalid),
        .evt_tready    (evt_tready),
        .evt_tlast     (evt_tlast),
        .drop_count_o  (drop_count_o)
    );

    always #5 clk = ~clk;

    // Reference timestamp: cycles since reset release.
    logic [47:0] tb_ts = '0;
    always @(posedge clk) tb_ts <= rst_i ? 48'd0 : tb_ts + 48'd1;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [15:0] exp_cnt = '0;
    evt_rec_t    exp_q[$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] beat_of(input evt_rec_t r, input int k);
        if (k == 0) return {r.ts, r.count};
        return r.meta[k-1];
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
        ce_i = ~ce_i;
    endtask

    task automatic push_exp(input logic [63:0] a, b, c, d);
        evt_rec_t r;
        r.ts = tb_ts;
        r.count = exp_cnt;
        r.meta[0] = a; r.meta[1] = b; r.meta[2] = c; r.meta[3] = d;
        exp_q.push_back(r);
        exp_cnt++;
    endtask

    task automatic do_trig(input logic [63:0] a, b, c, d, input bit accept);
        trig_i = 1'b1;
        tio0 = a; tio1 = b; tio2 = c; tio3 = d;
        if (accept) push_exp(a, b, c, d);
        tick;
        trig_i = 1'b0;
    endtask

    // Collects one 5-beat record and compares it to the scoreboard head.
    task automatic recv_record(input bit rnd, input bit trig_on_last);
        evt_rec_t    e;
        int          n = 0;
        int          cyc = 0;
        logic        prev_stall = 1'b0;
        logic [63:0] prev_data = '0;
        logic        prev_last = 1'b0;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
        while (n < 5 && cyc < 100) begin
            trig_i = 1'b0;
            evt_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (prev_stall && evt_tvalid) begin
                check_eq("stall_data", evt_tdata, prev_data);
                check_eq("stall_last", 64'(evt_tlast), 64'(prev_last));
            end
            prev_stall = evt_tvalid && !evt_tready;
            prev_data  = evt_tdata;
            prev_last  = evt_tlast;
            if (evt_tvalid && evt_tready) begin
                check_eq($sformatf("beat%0d", n), evt_tdata, beat_of(e, n));
                check_eq($sformatf("last%0d", n), 64'(evt_tlast), 64'(n == 4));
                if (trig_on_last && evt_tlast) begin
                    trig_i = 1'b1;
                    tio0 = 64'hC0DE_0000_0000_0001; tio1 = 64'hC0DE_0000_0000_0002;
                    tio2 = 64'hC0DE_0000_0000_0003; tio3 = 64'hC0DE_0000_0000_0004;
                    push_exp(tio0, tio1, tio2, tio3);
                end
                n++;
            end
            tick;
            cyc++;
        end
        trig_i = 1'b0;
        evt_tready = 1'b0;
        check_eq("rx_beats", 64'(n), 64'd5);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int hi;
        // Reset state
        tick; tick;
        check_eq("rst_tvalid", 64'(evt_tvalid), 64'd0);
        check_eq("rst_tlast", 64'(evt_tlast), 64'd0);
        check_eq("rst_tdata", evt_tdata, 64'd0);
        check_eq("rst_holdoff", 64'(holdoff_o), 64'd0);
        check_eq("rst_dead", 64'(dead_o), 64'd1);
        check_eq("rst_drop", 64'(drop_count_o), 64'd0);
        rst_i = 1'b0;
        tick;
        check_eq("dead_run_off", 64'(dead_o), 64'd1);
        run_en_i = 1'b1;
        tick; tick;
        check_eq("dead_run_on", 64'(dead_o), 64'd0);

        // Basic capture, latency, holdoff_len = 0
        do_trig(64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
                64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444, 1);
        check_eq("lat_n1_tvalid", 64'(evt_tvalid), 64'd0);
        check_eq("holdoff_zero_len", 64'(holdoff_o), 64'd0);
        tick;
        check_eq("lat_n2_tvalid", 64'(evt_tvalid), 64'd1);
        recv_record(0, 0);
        do_trig(64'hA5A5_0000_0000_0001, 64'h5A5A_0000_0000_0002,
                64'h0F0F_0000_0000_0003, 64'hF0F0_0000_0000_0004, 1);
        recv_record(0, 0);

        // Holdoff: 8 ce ticks with ce every other clock -> 16 clocks
        holdoff_len = 16'd8;
        while (ce_i !== 1'b1) tick;
        do_trig(64'h1, 64'h2, 64'h3, 64'h4, 1);
        hi = 0;
        check_eq("holdoff_n1", 64'(holdoff_o), 64'd1);
        for (int i = 0; i < 20; i++) begin
            if (holdoff_o) hi++;
            tick;
        end
        check_eq("holdoff_len16", 64'(hi), 64'd16);
        check_eq("holdoff_end", 64'(holdoff_o), 64'd0);
        holdoff_len = 16'd0;
        recv_record(0, 0);

        // Full queue, drop, simultaneous push/pop
        check_eq("pre_full_dead", 64'(dead_o), 64'd0);
        for (int i = 0; i < 16; i++)
            do_trig(64'(i), ~64'(i), 64'(i) << 8, 64'hF00D, 1);
        check_eq("dead_before_reg", 64'(dead_o), 64'd0);
        do_trig(64'hDEAD, 64'hDEAD, 64'hDEAD, 64'hDEAD, 0);
        check_eq("dead_full", 64'(dead_o), 64'd1);
        check_eq("drop_one", 64'(drop_count_o), 64'd1);
        recv_record(0, 1);
        check_eq("dead_simul", 64'(dead_o), 64'd1);
        check_eq("drop_simul", 64'(drop_count_o), 64'd1);
        tick;
        check_eq("dead_simul2", 64'(dead_o), 64'd1);
        recv_record(0, 0);
        tick;
        check_eq("dead_after_pop", 64'(dead_o), 64'd0);
        for (int i = 0; i < 15; i++) recv_record(0, 0);
        tick; tick;
        check_eq("drained_tvalid", 64'(evt_tvalid), 64'd0);

        // Reset mid-stream during beat 2
        evt_tready = 1'b1;
        do_trig(64'hAAAA, 64'hBBBB, 64'hCCCC, 64'hDDDD, 0);
        tick; tick; tick;
        check_eq("pre_rst_valid", 64'(evt_tvalid), 64'd1);
        check_eq("pre_rst_beat2", evt_tdata, 64'hBBBB);
        rst_i = 1'b1;
        run_en_i = 1'b0;
        #1;
        check_eq("async_tvalid", 64'(evt_tvalid), 64'd0);
        check_eq("async_tdata", evt_tdata, 64'd0);
        check_eq("async_drop", 64'(drop_count_o), 64'd0);
        tick;
        rst_i = 1'b0;
        evt_tready = 1'b0;
        check_eq("post_rst_dead", 64'(dead_o), 64'd1);
        tick;
        check_eq("post_rst_dead2", 64'(dead_o), 64'd1);
        check_eq("post_rst_tvalid", 64'(evt_tvalid), 64'd0);
        exp_q.delete();
        exp_cnt = '0;
        run_en_i = 1'b1;
        tick; tick;
        check_eq("post_rst_run", 64'(dead_o), 64'd0);
        do_trig(64'h7, 64'h8, 64'h9, 64'hA, 1);
        recv_record(0, 0);

        // Random backpressure over several queued records
        do_trig(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 64'h1, 64'h2, 1);
        tick;
        do_trig(64'h3, 64'h4, 64'h5, 64'h6, 1);
        do_trig(64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
        for (int i = 0; i < 3; i++) recv_record(1, 0);
        tick; tick;
        check_eq("final_tvalid", 64'(evt_tvalid), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
